// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: segment patterns, anode codes, count field layout and FSM encoding
// shared by the 7-segment scan decoder.
package seg_scan_pkg;
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

    localparam int F0_LSB = 0;
    localparam int F0_W   = 4;
    localparam int F1_LSB = 4;
    localparam int F1_W   = 3;
    localparam int F2_LSB = 7;
    localparam int F2_W   = 4;
    localparam int F3_LSB = 11;
    localparam int F3_W   = 3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } seg_dec_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } an_dec_t;

    function automatic an_dec_t an_decode(input logic [3:0] an);
        an_dec_t r;
        r.valid = an == AN_D0 || an == AN_D1 || an == AN_D2 || an == AN_D3;
        r.idx   = an == AN_D1 ? DIG1 : an == AN_D2 ? DIG2 : an == AN_D3 ? DIG3 : DIG0;
        return r;
    endfunction
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-low {a..g} pattern to {valid, value}; unknown patterns
// (including blank) decode to 0 with valid low.
module seg_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);
    always_comb begin
        dec.valid = 1'b1;
        dec.value = 4'd0;
        case (pattern)
            SEG_0:   dec.value = 4'd0;
            SEG_1:   dec.value = 4'd1;
            SEG_2:   dec.value = 4'd2;
            SEG_3:   dec.value = 4'd3;
            SEG_4:   dec.value = 4'd4;
            SEG_5:   dec.value = 4'd5;
            SEG_6:   dec.value = 4'd6;
            SEG_7:   dec.value = 4'd7;
            SEG_8:   dec.value = 4'd8;
            SEG_9:   dec.value = 4'd9;
            default: dec.valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers 4-digit MM:SS frames from a scanned active-low 7-segment bus.
// Optional SEG_DP_CAPTURE_EN reports the colon (dp on digit1) and flags dp on other digits.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segments,
    input  logic [3:0]  anode_active,
    input  logic        dp,
    output logic [13:0] count,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stalled,
    output logic        colon_seen
);
    localparam int SC_W = $clog2(STABLE_CYCLES + 1);

    logic [6:0]      seg_in_q, seg_in_d, seg_prev_q, seg_prev_d;
    logic [3:0]      an_in_q, an_in_d, an_prev_q, an_prev_d;
    logic [1:0]      state_q, state_d;
    logic [SC_W-1:0] stab_q, stab_d;
    logic [3:0]      mask_q, mask_d;
    logic            perr_q, perr_d;
    logic [13:0]     stage_q, stage_d, count_q, count_d;
    logic            fv_q, fv_d, ferr_q, ferr_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            cap, cap_err, done, dp_err;
    an_dec_t         an_dec;
    seg_dec_t        seg_dec;

    seg_pattern_decode u_dec (.pattern(seg_in_q), .dec(seg_dec));

    assign an_dec = an_decode(an_in_q);

    always_comb begin
        seg_in_d   = segments;
        an_in_d    = anode_active;
        seg_prev_d = seg_in_q;
        an_prev_d  = an_in_q;
        state_d    = state_q;
        stab_d     = stab_q;
        cap        = 1'b0;
        if (state_q == ST_IDLE) begin
            state_d = an_dec.valid ? ST_SETTLE : ST_IDLE;
            stab_d  = SC_W'(1);
        end else if (state_q == ST_SETTLE) begin
            if (!an_dec.valid)
                state_d = ST_IDLE;
            else if (an_in_q != an_prev_q || seg_in_q != seg_prev_q)
                stab_d = SC_W'(1);
            else if (stab_q + 1'b1 == SC_W'(STABLE_CYCLES)) begin
                state_d = ST_CAPTURED;
                cap     = 1'b1;
            end else
                stab_d = stab_q + 1'b1;
        end else if (an_in_q != an_prev_q) begin
            state_d = an_dec.valid ? ST_SETTLE : ST_IDLE;
            stab_d  = SC_W'(1);
        end
        // odd digits are the 0-7 tens fields; 8 or 9 there is out of range
        cap_err = !seg_dec.valid || (an_dec.idx[0] && seg_dec.value[3]) || dp_err;
        done    = mask_q == 4'hF;
        mask_d  = (done ? 4'h0 : mask_q) | (cap ? 4'b0001 << an_dec.idx : 4'h0);
        perr_d  = (done ? 1'b0 : perr_q) | (cap && cap_err);
        stage_d = stage_q;
        if (cap) begin
            if (an_dec.idx == DIG0) stage_d[F0_LSB +: F0_W] = seg_dec.value[F0_W-1:0];
            if (an_dec.idx == DIG1) stage_d[F1_LSB +: F1_W] = seg_dec.value[F1_W-1:0];
            if (an_dec.idx == DIG2) stage_d[F2_LSB +: F2_W] = seg_dec.value[F2_W-1:0];
            if (an_dec.idx == DIG3) stage_d[F3_LSB +: F3_W] = seg_dec.value[F3_W-1:0];
        end
        count_d = done ? stage_q : count_q;
        fv_d    = done;
        ferr_d  = done ? perr_q : ferr_q;
        to_d    = cap ? '0 : to_q == TO_W'(TIMEOUT_CYCLES) ? to_q : to_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_in_q   <= SEG_BLANK;
            seg_prev_q <= SEG_BLANK;
            an_in_q    <= 4'hF;
            an_prev_q  <= 4'hF;
            state_q    <= ST_IDLE;
            stab_q     <= '0;
            mask_q     <= 4'h0;
            perr_q     <= 1'b0;
            stage_q    <= '0;
            count_q    <= '0;
            fv_q       <= 1'b0;
            ferr_q     <= 1'b0;
            to_q       <= '0;
        end else begin
            seg_in_q   <= seg_in_d;
            seg_prev_q <= seg_prev_d;
            an_in_q    <= an_in_d;
            an_prev_q  <= an_prev_d;
            state_q    <= state_d;
            stab_q     <= stab_d;
            mask_q     <= mask_d;
            perr_q     <= perr_d;
            stage_q    <= stage_d;
            count_q    <= count_d;
            fv_q       <= fv_d;
            ferr_q     <= ferr_d;
            to_q       <= to_d;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic dp_in_q, dp_in_d, colon_pend_q, colon_pend_d, colon_q, colon_d;

    always_comb begin
        dp_in_d      = dp;
        dp_err       = !dp_in_q && an_dec.idx != DIG1;
        colon_pend_d = (done ? 1'b0 : colon_pend_q) | (cap && !dp_in_q && an_dec.idx == DIG1);
        colon_d      = done ? colon_pend_q : colon_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_in_q      <= 1'b1;
            colon_pend_q <= 1'b0;
            colon_q      <= 1'b0;
        end else begin
            dp_in_q      <= dp_in_d;
            colon_pend_q <= colon_pend_d;
            colon_q      <= colon_d;
        end
    end

    assign colon_seen = colon_q;
`else
    logic unused_dp;
    assign unused_dp  = dp;
    assign dp_err     = 1'b0;
    assign colon_seen = 1'b0;
`endif

    assign count       = count_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign stalled     = to_q == TO_W'(TIMEOUT_CYCLES);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: drives scanned digit frames (fixed and $urandom) and checks the
// recovered frames against a table-driven model of the display format.
module tb_seg_scan_decoder;
    localparam int STABLE = 16;
    localparam int TMO    = 200;
    localparam int HOLD   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dp = 1'b1;
    logic [6:0]  segments = 7'h7F;
    logic [3:0]  anode_active = 4'hF;
    logic [13:0] count;
    logic        frame_valid, frame_err, stalled, colon_seen;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fv_n = 0;
    int          fv_cyc = 0;
    logic [13:0] got_count = '0;
    logic        got_err = 1'b0;
    logic        got_colon = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .segments(segments), .anode_active(anode_active), .dp(dp),
        .count(count), .frame_valid(frame_valid), .frame_err(frame_err),
        .stalled(stalled), .colon_seen(colon_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_n      <= fv_n + 1;
            fv_cyc    <= cyc;
            got_count <= count;
            got_err   <= frame_err;
            got_colon <= colon_seen;
        end
    end

    function automatic int pat_val(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tbl[i] == p) return i;
        return -1;
    endfunction

    // {colon, err, count} for a frame showing patterns p with active-low dp flags dpl
    function automatic logic [15:0] model(input logic [3:0][6:0] p, input logic [3:0] dpl);
        int v [4];
        logic e, c, dp_on;
        e = 1'b0;
        c = 1'b0;
        dp_on = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
        dp_on = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            v[i] = pat_val(p[i]);
            if (v[i] < 0) begin
                e = 1'b1;
                v[i] = 0;
            end
            if (dp_on && !dpl[i]) begin
                if (i == 1) c = 1'b1;
                else e = 1'b1;
            end
        end
        if (v[1] > 7 || v[3] > 7) e = 1'b1;
        return {c, e, 14'((v[3] % 8) * 2048 + v[2] * 128 + (v[1] % 8) * 16 + v[0])};
    endfunction

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input logic d, input int n);
        anode_active = an;
        segments = sg;
        dp = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [3:0][6:0] p, input logic [3:0] dpl, input int blank);
        for (int i = 0; i < 4; i++) hold(an_tbl[i], p[i], dpl[i], HOLD);
        if (blank > 0) hold(4'hF, 7'h7F, 1'b1, blank);
    endtask

    task automatic test_reset();
        hold(4'b1110, 7'h4C, 1'b0, 4);
        total += 5;
        if (count !== 14'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", count); end
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled: got %b want 0", stalled); end
        if (colon_seen !== 1'b0) begin bad++; $display("FAIL reset_colon: got %b want 0", colon_seen); end
        hold(4'hF, 7'h7F, 1'b1, 2);
        rst = 1'b1;
        hold(4'hF, 7'h7F, 1'b1, 3);
    endtask

    task automatic test_clean();
        logic [3:0][6:0] p;
        int n0, c0;
        p = {7'h4F, 7'h12, 7'h06, 7'h4C};
        n0 = fv_n;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c0 = cyc;
            hold(an_tbl[i], p[i], 1'b1, HOLD);
        end
        hold(4'hF, 7'h7F, 1'b1, 3);
        total += 4;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL clean_pulses: got %0d want 1", fv_n - n0); end
        if (got_count !== 14'b001_0010_011_0100) begin bad++; $display("FAIL clean_count: got %b want 00100100110100", got_count); end
        if (got_err !== 1'b0) begin bad++; $display("FAIL clean_err: got %b want 0", got_err); end
        if (fv_cyc - c0 < STABLE + 1 || fv_cyc - c0 > STABLE + 4)
            begin bad++; $display("FAIL clean_latency: got %0d want %0d..%0d", fv_cyc - c0, STABLE + 1, STABLE + 4); end
    endtask

    task automatic test_glitch();
        logic [3:0][6:0] p;
        logic [15:0] m;
        int n0;
        p = {7'h4F, 7'h24, 7'h12, 7'h0F};
        m = model(p, 4'hF);
        n0 = fv_n;
        for (int i = 1; i < 4; i++) hold(an_tbl[i], p[i], 1'b1, HOLD);
        hold(an_tbl[0], 7'h0F, 1'b1, 6);
        hold(an_tbl[0], 7'h00, 1'b1, 5);
        hold(an_tbl[0], 7'h0F, 1'b1, HOLD);
        hold(4'hF, 7'h7F, 1'b1, 3);
        total += 3;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL glitch_pulses: got %0d want 1", fv_n - n0); end
        if (got_count !== m[13:0]) begin bad++; $display("FAIL glitch_count: got %0h want %0h", got_count, m[13:0]); end
        if (got_err !== 1'b0) begin bad++; $display("FAIL glitch_err: got %b want 0", got_err); end
    endtask

    task automatic test_invalid();
        logic [3:0][6:0] p;
        logic [15:0] m;
        int n0;
        p = {seg_tbl[2], 7'h7F, seg_tbl[4], seg_tbl[9]};
        m = model(p, 4'hF);
        n0 = fv_n;
        scan(p, 4'hF, 3);
        total += 4;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL invalid_pulses: got %0d want 1", fv_n - n0); end
        if (got_err !== 1'b1) begin bad++; $display("FAIL invalid_err: got %b want 1", got_err); end
        if (got_count[10:7] !== 4'd0) begin bad++; $display("FAIL invalid_field: got %0h want 0", got_count[10:7]); end
        if (got_count !== m[13:0]) begin bad++; $display("FAIL invalid_count: got %0h want %0h", got_count, m[13:0]); end
    endtask

    task automatic test_range();
        logic [3:0][6:0] p;
        int n0;
        p = {seg_tbl[1], seg_tbl[8], seg_tbl[9], seg_tbl[0]};
        n0 = fv_n;
        scan(p, 4'hF, 3);
        total += 3;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL range_pulses: got %0d want 1", fv_n - n0); end
        if (got_err !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", got_err); end
        if (got_count[6:4] !== 3'b001) begin bad++; $display("FAIL range_field: got %b want 001", got_count[6:4]); end
    endtask

    task automatic test_back_to_back();
        logic [3:0][6:0] p;
        logic [3:0] dpl;
        logic [15:0] m;
        int n0;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                p[i] = seg_tbl[$urandom_range(0, 9)];
                if ($urandom_range(0, 7) == 0)
                    do p[i] = 7'($urandom); while (pat_val(p[i]) >= 0);
                dpl[i] = $urandom_range(0, 3) != 0;
            end
            m = model(p, dpl);
            n0 = fv_n;
            scan(p, dpl, 0);
            total += 4;
            if (fv_n - n0 != 1) begin bad++; $display("FAIL b2b_pulses[%0d]: got %0d want 1", f, fv_n - n0); end
            if (got_count !== m[13:0]) begin bad++; $display("FAIL b2b_count[%0d]: got %0h want %0h", f, got_count, m[13:0]); end
            if (got_err !== m[14]) begin bad++; $display("FAIL b2b_err[%0d]: got %b want %b", f, got_err, m[14]); end
            if (got_colon !== m[15]) begin bad++; $display("FAIL b2b_colon[%0d]: got %b want %b", f, got_colon, m[15]); end
        end
        hold(4'hF, 7'h7F, 1'b1, 3);
    endtask

    task automatic test_stall();
        logic [3:0][6:0] p;
        logic [15:0] m;
        int n0;
        p = {seg_tbl[5], seg_tbl[3], seg_tbl[6], seg_tbl[7]};
        m = model(p, 4'hF);
        hold(4'hF, 7'h7F, 1'b1, 5);
        total += 1;
        if (stalled !== 1'b0) begin bad++; $display("FAIL stall_early: got %b want 0", stalled); end
        hold(4'hF, 7'h7F, 1'b1, TMO + 10);
        total += 1;
        if (stalled !== 1'b1) begin bad++; $display("FAIL stall_set: got %b want 1", stalled); end
        n0 = fv_n;
        hold(an_tbl[0], p[0], 1'b1, 5);
        total += 1;
        if (stalled !== 1'b1) begin bad++; $display("FAIL stall_hold: got %b want 1", stalled); end
        hold(an_tbl[0], p[0], 1'b1, HOLD - 5);
        total += 1;
        if (stalled !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b want 0", stalled); end
        for (int i = 1; i < 4; i++) hold(an_tbl[i], p[i], 1'b1, HOLD);
        hold(4'hF, 7'h7F, 1'b1, 3);
        total += 2;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", fv_n - n0); end
        if (got_count !== m[13:0]) begin bad++; $display("FAIL stall_count: got %0h want %0h", got_count, m[13:0]); end
    endtask

    task automatic test_reset_mid();
        logic [3:0][6:0] p;
        logic [15:0] m;
        int n0;
        p = {seg_tbl[2], seg_tbl[1], seg_tbl[4], seg_tbl[8]};
        m = model(p, 4'b1101);
        hold(an_tbl[0], seg_tbl[3], 1'b1, HOLD);
        hold(an_tbl[1], seg_tbl[5], 1'b1, HOLD);
        hold(an_tbl[2], seg_tbl[6], 1'b1, 8);
        #2 rst = 1'b0;
        #1;
        total += 5;
        if (count !== 14'd0) begin bad++; $display("FAIL mid_count: got %0h want 0", count); end
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_fv: got %b want 0", frame_valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", frame_err); end
        if (stalled !== 1'b0) begin bad++; $display("FAIL mid_stalled: got %b want 0", stalled); end
        if (colon_seen !== 1'b0) begin bad++; $display("FAIL mid_colon: got %b want 0", colon_seen); end
        @(posedge clk);
        #1;
        hold(4'hF, 7'h7F, 1'b1, 3);
        rst = 1'b1;
        hold(4'hF, 7'h7F, 1'b1, 2);
        n0 = fv_n;
        scan(p, 4'b1101, 3);
        total += 4;
        if (fv_n - n0 != 1) begin bad++; $display("FAIL mid_pulses: got %0d want 1", fv_n - n0); end
        if (got_count !== m[13:0]) begin bad++; $display("FAIL mid_frame: got %0h want %0h", got_count, m[13:0]); end
        if (got_err !== m[14]) begin bad++; $display("FAIL mid_frame_err: got %b want %b", got_err, m[14]); end
        if (got_colon !== m[15]) begin bad++; $display("FAIL mid_colon_seen: got %b want %b", got_colon, m[15]); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_invalid();
        test_range();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
